// File: rtl/framebuf_pkg.sv
// framebuf_pkg: shared widths and slot encoding
// for the framebuffer RAM arbiter.
package framebuf_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VID     = 2'd1,
    HOST_RD = 2'd2,
    HOST_WR = 2'd3
  } slot_e;

endpackage

// File: rtl/framebuf_ram_arbiter.sv
// framebuf_ram_arbiter: one RAM access per clock,
// video first, host in free or forced slots.
module framebuf_ram_arbiter
  import framebuf_pkg::*;
#(
  parameter int ADDR_W        = framebuf_pkg::ADDR_W,
  parameter int DATA_W        = framebuf_pkg::DATA_W,
  parameter int MAX_HOST_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int WW = $clog2(MAX_HOST_WAIT + 2);
  localparam logic [WW-1:0] WMAX = WW'(MAX_HOST_WAIT);

  slot_e             state;
  slot_e             state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              we_nxt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_nxt;
  logic              pend;
  logic              pend_nxt;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] pend_addr_nxt;
  logic [WW-1:0]     wait_cnt;
  logic [WW-1:0]     wait_nxt;
  logic              ovr_nxt;

  logic slot_vid;
  logic slot_rd;
  logic slot_wr;
  logic host_busy;
  logic host_elig;
  logic host_force;
  logic host_grant;

  // The write driver lives at the port; reads leave the bus to the RAM.
  assign ram_data = ram_we ? wdata_q : {DATA_W{1'bz}};

  // Slot, RAM control and arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      wdata_q     <= '0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      wait_cnt    <= '0;
      vid_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      ram_addr    <= addr_nxt;
      ram_we      <= we_nxt;
      wdata_q     <= wdata_nxt;
      pend        <= pend_nxt;
      pend_addr   <= pend_addr_nxt;
      wait_cnt    <= wait_nxt;
      vid_overrun <= ovr_nxt;
    end
  end

  // Grant decision for the next slot, in strict priority order.
  always_comb begin
    state_nxt     = IDLE;
    addr_nxt      = ram_addr;
    we_nxt        = 1'b0;
    wdata_nxt     = wdata_q;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;
    ovr_nxt       = vid_overrun;
    host_grant    = 1'b0;
    wait_nxt      = wait_cnt;

    host_elig  = host_req & ~host_busy & ~host_ack;
    host_force = host_elig & (wait_cnt == WMAX);

    if (host_force) begin
      host_grant = 1'b1;
      if (vid_req) begin
        if (pend) begin
          ovr_nxt = 1'b1;
        end else begin
          pend_nxt      = 1'b1;
          pend_addr_nxt = vid_addr;
        end
      end
    end else if (pend) begin
      state_nxt = VID;
      addr_nxt  = pend_addr;
      if (vid_req) begin
        pend_addr_nxt = vid_addr;
      end else begin
        pend_nxt = 1'b0;
      end
    end else if (vid_req) begin
      state_nxt = VID;
      addr_nxt  = vid_addr;
    end else if (host_elig) begin
      host_grant = 1'b1;
    end

    if (host_grant) begin
      state_nxt = host_we ? HOST_WR : HOST_RD;
      addr_nxt  = host_addr;
      we_nxt    = host_we;
      if (host_we) begin
        wdata_nxt = host_wdata;
      end
    end

    if (!host_req || host_grant) begin
      wait_nxt = '0;
    end else if (host_elig && wait_cnt != WMAX) begin
      wait_nxt = wait_cnt + WW'(1);
    end
  end

  // Decode the slot currently on the RAM.
  always_comb begin
    slot_vid = 1'b0;
    slot_rd  = 1'b0;
    slot_wr  = 1'b0;
    unique case (state)
      VID:     slot_vid = 1'b1;
      HOST_RD: slot_rd  = 1'b1;
      HOST_WR: slot_wr  = 1'b1;
      default: ;
    endcase
    host_busy = slot_rd | slot_wr;
  end

  // Capture RAM read data at the end of each slot and pulse completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_valid  <= 1'b0;
      vid_data   <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      vid_valid <= slot_vid;
      host_ack  <= slot_rd | slot_wr;
      if (slot_vid) begin
        vid_data <= ram_data;
      end
      if (slot_rd) begin
        host_rdata <= ram_data;
      end
    end
  end

endmodule

// File: tb/tb_framebuf_ram_arbiter.sv
// tb_framebuf_ram_arbiter: directed checks of the
// framebuffer RAM arbiter against a simple RAM model.
module tb_framebuf_ram_arbiter;
  import framebuf_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  wire  [DW-1:0] ram_data;

  logic [DW-1:0] mem [1024];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  int n_run  = 0;
  int n_fail = 0;
  int nv;
  int ack_at;
  int acks;

  framebuf_ram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_HOST_WAIT(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .vid_valid(vid_valid),
    .vid_overrun(vid_overrun),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Combinational-read, edge-write RAM model.
  assign ram_data = ram_we ? {DW{1'bz}} : mem[ram_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_addr] <= ram_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_vid_valid", vid_valid, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_overrun", vid_overrun, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    reset = 1'b1;
    tick();

    load(10'h010, 8'hC3);
    for (int i = 0; i < 20; i++)
      load(AW'(10'h200 + i), DW'(8'h40 + i));
    load(10'h055, 8'h11);
    tick();

    // host write with idle video
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 10'h123;
    host_wdata = 8'h5A;
    tick();
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_addr, 10'h123);
    check("wr_bus", ram_data, 8'h5A);
    check("wr_no_early_ack", host_ack, 0);
    tick();
    check("wr_we_once", ram_we, 0);
    check("wr_ack", host_ack, 1);
    host_req = 1'b0;
    host_we = 1'b0;
    tick();
    check("wr_ack_pulse", host_ack, 0);
    check("wr_mem", mem[10'h123], 8'h5A);

    // host read, request held through the ack cycle
    host_req = 1'b1;
    host_addr = 10'h123;
    tick();
    check("rd_we", ram_we, 0);
    check("rd_addr", ram_addr, 10'h123);
    tick();
    check("rd_ack", host_ack, 1);
    check("rd_data", host_rdata, 8'h5A);
    tick();
    host_req = 1'b0;
    check("rd_no_regrant1", host_ack, 0);
    tick();
    check("rd_no_regrant2", host_ack, 0);
    tick();

    // simultaneous video and host: video first
    vid_req = 1'b1;
    vid_addr = 10'h010;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 10'h123;
    tick();
    vid_req = 1'b0;
    check("arb_vid_slot", ram_addr, 10'h010);
    tick();
    check("arb_vid_valid", vid_valid, 1);
    check("arb_vid_data", vid_data, 8'hC3);
    check("arb_host_slot", ram_addr, 10'h123);
    check("arb_host_wait", host_ack, 0);
    tick();
    check("arb_host_ack", host_ack, 1);
    check("arb_host_data", host_rdata, 8'h5A);
    host_req = 1'b0;
    tick();

    // continuous video, one host read forced in
    nv = 0;
    ack_at = -1;
    host_addr = 10'h123;
    for (int i = 0; i < 24; i++) begin
      vid_req = (i < 20);
      vid_addr = AW'(10'h200 + i);
      host_req = (i < 10);
      tick();
      if (vid_valid) begin
        check("stream_data", vid_data, DW'(8'h40 + nv));
        nv++;
      end
      if (host_ack) ack_at = i + 1;
    end
    check("stream_valids", nv, 20);
    check("stream_ack_cycle", ack_at, 9);
    check("stream_overrun", vid_overrun, 0);

    // two forced host slots under the same stream: second overflows pend
    nv = 0;
    acks = 0;
    for (int i = 0; i < 24; i++) begin
      vid_req = (i < 20);
      vid_addr = AW'(10'h200 + i);
      host_req = (i < 20);
      tick();
      if (i + 1 == 17) check("ovr_before", vid_overrun, 0);
      if (i + 1 == 18) check("ovr_set", vid_overrun, 1);
      if (vid_valid) nv++;
      if (host_ack) acks++;
    end
    check("ovr_valids", nv, 19);
    check("ovr_acks", acks, 2);
    repeat (3) tick();
    check("ovr_sticky", vid_overrun, 1);

    // reset in the middle of a host write slot
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 10'h055;
    host_wdata = 8'h77;
    tick();
    check("mid_pre_we", ram_we, 1);
    reset = 1'b0;
    #1;
    check("mid_we", ram_we, 0);
    check("mid_addr", ram_addr, 0);
    check("mid_overrun", vid_overrun, 0);
    check("mid_vid_data", vid_data, 0);
    check("mid_rdata", host_rdata, 0);
    check("mid_valid", vid_valid, 0);
    tick();
    check("mid_no_ack", host_ack, 0);
    check("mid_no_write", mem[10'h055], 8'h11);
    reset = 1'b1;
    tick();
    check("re_we", ram_we, 1);
    check("re_addr", ram_addr, 10'h055);
    tick();
    check("re_ack", host_ack, 1);
    host_req = 1'b0;
    host_we = 1'b0;
    tick();
    check("re_mem", mem[10'h055], 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
